// File: rtl/rs15_9_encoder.sv
// RS(15,9) systematic encoder over GF(16): 6-stage LFSR, one message symbol per clock.
// Latency 10 cycles from accepted start to done; start is ignored while busy (no queuing).
// Backpressure: none downstream; codeword_out holds until the next done. Option: RS15_9_ENCODER_SELFCHECK_EN adds check_err.
module rs15_9_encoder #(
    parameter int SYM_W = 4,
    parameter int N_SYM = 15,
    parameter int K_SYM = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [K_SYM*SYM_W-1:0]   message_in,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [N_SYM*SYM_W-1:0]   codeword_out
`ifdef RS15_9_ENCODER_SELFCHECK_EN
    ,
    output logic                     check_err
`endif
);

    localparam int P_SYM = N_SYM - K_SYM;
    // g0 in the low nibble up to g5 in the high nibble
    localparam logic [P_SYM*SYM_W-1:0] G_COEF = {4'h7, 4'h9, 4'h3, 4'hC, 4'hA, 4'hC};

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a, input logic [SYM_W-1:0] b);
        logic [SYM_W-1:0] acc;
        logic [SYM_W-1:0] t;
        acc = '0;
        t   = a;
        for (int i = 0; i < SYM_W; i++) begin
            if (b[i]) acc = acc ^ t;
            t = {t[SYM_W-2:0], 1'b0} ^ (t[SYM_W-1] ? 4'b0011 : 4'b0000);
        end
        return acc;
    endfunction

    state_t                     r_state;
    logic [3:0]                 r_cnt;
    logic [K_SYM*SYM_W-1:0]     r_msg;
    logic [P_SYM*SYM_W-1:0]     r_par;

    logic [SYM_W-1:0]           w_sym;
    logic [SYM_W-1:0]           w_fb;
    logic [P_SYM*SYM_W-1:0]     w_par_nxt;
    logic [N_SYM*SYM_W-1:0]     w_cw;

    // Highest message symbol enters the LFSR first
    always_comb begin
        w_sym = '0;
        for (int k = 0; k < K_SYM; k++) begin
            if (r_cnt == 4'(K_SYM - 1 - k)) w_sym = r_msg[k*SYM_W +: SYM_W];
        end
    end

    always_comb begin
        w_fb = w_sym ^ r_par[(P_SYM-1)*SYM_W +: SYM_W];
        w_par_nxt = '0;
        w_par_nxt[SYM_W-1:0] = gf_mul(w_fb, G_COEF[SYM_W-1:0]);
        for (int j = 1; j < P_SYM; j++) begin
            w_par_nxt[j*SYM_W +: SYM_W] = r_par[(j-1)*SYM_W +: SYM_W] ^ gf_mul(w_fb, G_COEF[j*SYM_W +: SYM_W]);
        end
    end

    assign w_cw = {r_msg, r_par};

`ifdef RS15_9_ENCODER_SELFCHECK_EN
    logic [SYM_W-1:0] w_s1;
    // Horner evaluation of the codeword polynomial at alpha
    always_comb begin
        w_s1 = '0;
        for (int i = N_SYM - 1; i >= 0; i--) begin
            w_s1 = gf_mul(w_s1, 4'h2) ^ w_cw[i*SYM_W +: SYM_W];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_msg        <= '0;
            r_par        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            codeword_out <= '0;
`ifdef RS15_9_ENCODER_SELFCHECK_EN
            check_err    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_msg   <= message_in;
                        r_par   <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_par <= w_par_nxt;
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'(K_SYM - 1)) r_state <= S_DONE;
                end
                S_DONE: begin
                    codeword_out <= w_cw;
                    done         <= 1'b1;
                    busy         <= 1'b0;
`ifdef RS15_9_ENCODER_SELFCHECK_EN
                    check_err    <= (w_s1 != '0);
`endif
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rs15_9_encoder.sv
// Bench for rs15_9_encoder: directed sequence plus random messages checked against
// a long-division GF(16) reference model and syndrome evaluation.
module tb_rs15_9_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [35:0] message_in;
    logic        busy;
    logic        done;
    logic [59:0] codeword_out;
`ifdef RS15_9_ENCODER_SELFCHECK_EN
    logic        check_err;
`endif

    int total = 0;
    int bad   = 0;

    int gexp [0:14];
    int glog [0:15];
    int gpoly [0:6];

    always #5 clk = ~clk;

    rs15_9_encoder dut (
        .clk          (clk),
        .reset        (reset),
        .message_in   (message_in),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .codeword_out (codeword_out)
`ifdef RS15_9_ENCODER_SELFCHECK_EN
        ,
        .check_err    (check_err)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return gexp[(glog[a] + glog[b]) % 15];
    endfunction

    // Power table of alpha, then g(x) built as the product of (x + alpha^r), r=1..6
    task automatic init_gf();
        int v;
        v = 1;
        for (int i = 0; i < 15; i++) begin
            gexp[i] = v;
            glog[v] = i;
            v = v << 1;
            if ((v & 16) != 0) v = v ^ 19;
        end
        glog[0] = 0;
        for (int j = 0; j < 7; j++) gpoly[j] = 0;
        gpoly[0] = 1;
        for (int r = 1; r <= 6; r++) begin
            for (int j = 6; j >= 0; j--) begin
                gpoly[j] = ((j > 0) ? gpoly[j-1] : 0) ^ gmul(gpoly[j], gexp[r]);
            end
        end
    endtask

    // Parity = remainder of m(x)*x^6 divided by g(x)
    function automatic logic [59:0] ref_cw(input logic [35:0] msg);
        int r [0:14];
        int c;
        logic [59:0] cw;
        for (int i = 0; i < 15; i++) r[i] = 0;
        for (int k = 0; k < 9; k++) r[k+6] = int'(msg[4*k +: 4]);
        for (int d = 14; d >= 6; d--) begin
            c = r[d];
            for (int j = 0; j <= 6; j++) r[d-6+j] = r[d-6+j] ^ gmul(c, gpoly[j]);
        end
        cw = '0;
        cw[59:24] = msg;
        for (int i = 0; i < 6; i++) cw[4*i +: 4] = 4'(r[i]);
        return cw;
    endfunction

    function automatic logic syn_zero(input logic [59:0] cw);
        int s;
        for (int k = 1; k <= 6; k++) begin
            s = 0;
            for (int i = 0; i < 15; i++) s = s ^ gmul(int'(cw[4*i +: 4]), gexp[(k*i) % 15]);
            if (s != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [35:0] rnd36();
        return {4'($urandom), $urandom};
    endfunction

    // Waits (bounded) for done; message_in is scrambled once the start has been taken
    task automatic run_to_done(input bit hold_start, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!hold_start) start = 1'b0;
            if (n == 1) message_in = rnd36();
        end while (!done && n < 30);
    endtask

    initial begin
        int n;
        int ndone;
        logic [35:0] m;
        logic [59:0] cw_seen;

        init_gf();
        reset = 1'b1;
        start = 1'b0;
        message_in = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_cw", 64'(codeword_out), 64'd0);
        reset = 1'b0;

        // All-zero message
        message_in = '0;
        start = 1'b1;
        run_to_done(1'b0, n);
        chk("zero_latency", 64'(n), 64'd11);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_cw", 64'(codeword_out), 64'd0);
        chk("zero_busy_low", 64'(busy), 64'd0);
        @(negedge clk);
        chk("zero_done_pulse", 64'(done), 64'd0);

        // Message 1 yields g(x) itself
        message_in = 36'h1;
        start = 1'b1;
        run_to_done(1'b0, n);
        chk("one_latency", 64'(n), 64'd11);
        chk("one_cw_const", 64'(codeword_out), 64'h0000_0000_0179_3CAC);
        chk("one_cw_model", 64'(codeword_out), 64'(ref_cw(36'h1)));

        // Start pulses during an encode are ignored
        m = rnd36();
        message_in = m;
        start = 1'b1;
        ndone = 0;
        cw_seen = '0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            start = (i == 3 || i == 7);
            if (i == 2) message_in = rnd36();
            if (done) begin
                ndone++;
                cw_seen = codeword_out;
            end
        end
        start = 1'b0;
        chk("ignored_start_count", 64'(ndone), 64'd1);
        chk("ignored_start_cw", 64'(cw_seen), 64'(ref_cw(m)));

        // Reset in the middle of SHIFT
        message_in = rnd36();
        start = 1'b1;
        repeat (5) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("mid_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_cw", 64'(codeword_out), 64'd0);
        reset = 1'b0;
        m = rnd36();
        message_in = m;
        start = 1'b1;
        run_to_done(1'b0, n);
        chk("after_rst_latency", 64'(n), 64'd11);
        chk("after_rst_cw", 64'(codeword_out), 64'(ref_cw(m)));

        // Start held high: back-to-back encodes every 11 cycles
        m = rnd36();
        message_in = m;
        start = 1'b1;
        for (int it = 0; it < 20; it++) begin
            run_to_done(1'b1, n);
            chk("stream_interval", 64'(n), 64'd11);
            chk("stream_cw", 64'(codeword_out), 64'(ref_cw(m)));
            chk("stream_msg_field", 64'(codeword_out[59:24]), 64'(m));
            chk("stream_syndromes", 64'(syn_zero(codeword_out)), 64'd1);
`ifdef RS15_9_ENCODER_SELFCHECK_EN
            chk("stream_check_err", 64'(check_err), 64'd0);
`endif
            m = rnd36();
            message_in = m;
            if (it == 19) start = 1'b0;
        end
        repeat (15) @(negedge clk);
        chk("final_idle_busy", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
